prefix_sub_pipe: RTL and testbench
==================================

// Module: prefix_sub_pipe
// PURPOSE
//  64-bit two-stage pipelined subtractor, the inverse operation of the team's KPG prefix adder.
//  Computes diff = a - b - bin as a + ~b + ~bin (radix-2 Kogge-Stone KPG prefix, 6 levels).
//  Sits in the VLIW integer lane beside the adder. Feeds compare/branch logic through
//  borrow, zero, negative and overflow flags. Uses a valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH        64  operand width; a power of 2 >= 8; prefix levels = log2(WIDTH)
//  SPLIT_LEVEL  3   prefix levels (spans 1,2,4) done in stage 1; remaining levels (8,16,32) in stage 2
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat present
//  in_ready   out  1      unit accepts beat this cycle
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow-in (1 = subtract one more)
//  out_valid  out  1      result beat present
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//  bout       out  1      borrow-out = ~carry(WIDTH); 1 iff unsigned a < b + bin
//  zero       out  1      diff == 0
//  neg        out  1      diff[WIDTH-1]
//  ovf        out  1      signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])
// BEHAVIOUR
//  - Reset (async, immediate): s1_valid = s2_valid = 0; out_valid = 0; diff/bout/zero/neg/ovf = 0.
//    In-flight beats are discarded. Nothing from before reset ever appears on the output.
//  - Cell encoding per bit i: (a_i, ~b_i) -> K/P/G. Carry-in position 0 = ~bin (forced K or G).
//  - Stage 1 (on in_valid && in_ready): register the KPG vector after SPLIT_LEVEL prefix levels,
//    plus p = a ^ ~b, a[MSB] and b[MSB].
//  - Stage 2: apply the remaining levels. diff[i] = p[i] ^ carry[i]; bout = ~carry[WIDTH].
//    Flags are computed from diff, then all of it is registered.
//  - Latency: 2 cycles from accept to out_valid when there is no backpressure.
//    Throughput: 1 beat per cycle.
//  - Handshake:
//    - s2_free  = !s2_valid || out_ready
//    - in_ready = !s1_valid || s2_free (combinational from out_ready; no in_valid dependency)
//    - A beat transfers when valid && ready on that edge.
//    - Once out_valid is asserted, diff and the flags hold stable until out_ready is sampled high.
//    - Accepting a new input and emitting an output in the same cycle is legal and loses no beat.
//  - Boundaries:
//    - Full stall (both stages valid, out_ready = 0): in_ready = 0 and no register changes.
//    - When out_ready rises, s2 drains and s1 advances on the same edge.
//    - The pipeline holds at most 2 beats; there is no skid buffer.
//    - Wrap-around: 0 - 1 gives all-ones, bout = 1, neg = 1, zero = 0.
//    - Equal operands with bin = 0 give zero = 1, bout = 0.
//  - No X on the outputs while out_valid = 0; those registers hold their last value.
// STRUCTURE
//  - Shared package (vliw_alu_pkg):
//    - KPG 2-bit encoding: KPG_K = 2'b00, KPG_P = 2'b10, KPG_G = 2'b11.
//    - KPG combine function: the higher-indexed cell wins unless it is P, in which case the lower one passes.
//    - Level count localparam LVLS = $clog2(WIDTH).
//  - Sub-module kpg_prefix_levels #(WIDTH, FIRST_SPAN, NUM_LVLS): a combinational generate-loop of
//    KPG combine levels. It is instantiated once per stage (FIRST_SPAN = 1, then 8), with the
//    stage registers between the two instances.
// TESTING
//  1. Reset: assert rst mid-stream with 2 beats in flight. Required: out_valid drops at once,
//     no stale beat after release, in_ready = 1 on the next edge.
//  2. Basic: a = 0x10, b = 0x3, bin = 0. Required: diff = 0xD, bout = 0, zero = 0, neg = 0, ovf = 0,
//     out_valid exactly 2 cycles after accept.
//  3. Wrap and borrow: a = 0, b = 1, bin = 0. Required: diff = 0xFFFF_FFFF_FFFF_FFFF, bout = 1, neg = 1.
//     Then a = 5, b = 5, bin = 1. Required: diff = all-ones, bout = 1.
//  4. Signed overflow: a = 0x8000_0000_0000_0000, b = 1. Required: diff = 0x7FFF_FFFF_FFFF_FFFF,
//     ovf = 1, bout = 0. Also a = b = 0x1234 with bin = 0: zero = 1.
//  5. Backpressure: stream 6 beats with out_ready = 0 for 4 cycles.
//     Required: in_ready = 0 after 2 accepts, diff held stable, then all 6 results in order, none lost.
//  6. Random: 10k random a/b/bin with random valid and ready. Compare against a golden model
//     {bout, diff} = {1'b0, a} - b - bin (bout = MSB of the WIDTH+1-bit result) and check order.

Source files
------------

// File: rtl/vliw_alu_pkg.sv
// Shared definitions for the VLIW integer lane adders/subtractors.
//  - kpg_t: 2-bit Kill/Propagate/Generate cell encoding
//  - kpg_cell: build a cell from one operand bit pair
//  - kpg_combine: prefix operator (higher cell wins unless it propagates)
//  - LVLS: prefix level count for the default 64-bit lane
package vliw_alu_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int LVLS      = $clog2(DEF_WIDTH);

    typedef logic [1:0] kpg_t;

    localparam kpg_t KPG_K = 2'b00;
    localparam kpg_t KPG_P = 2'b10;
    localparam kpg_t KPG_G = 2'b11;

    function automatic kpg_t kpg_cell(input logic x, input logic y);
        if (x & y) begin
            return KPG_G;
        end else if (x ^ y) begin
            return KPG_P;
        end else begin
            return KPG_K;
        end
    endfunction

    function automatic kpg_t kpg_combine(input kpg_t hi, input kpg_t lo);
        return (hi == KPG_P) ? lo : hi;
    endfunction

endpackage

// File: rtl/kpg_prefix_levels.sv
// Combinational Kogge-Stone KPG prefix levels.
//  kin  : WIDTH KPG cells, index 0 is the least significant position
//  kout : cells after NUM_LVLS levels with spans FIRST_SPAN, 2*FIRST_SPAN, ...
// Cells whose index is below the span of a level pass through unchanged.
module kpg_prefix_levels
    import vliw_alu_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int FIRST_SPAN = 1,
    parameter int NUM_LVLS   = 3
) (
    input  kpg_t [WIDTH-1:0] kin,
    output kpg_t [WIDTH-1:0] kout
);

    kpg_t lvl [NUM_LVLS+1][WIDTH];

    genvar l, j;
    generate
        for (j = 0; j < WIDTH; j++) begin : g_in
            assign lvl[0][j] = kin[j];
        end

        for (l = 0; l < NUM_LVLS; l++) begin : g_lvl
            localparam int SPAN = FIRST_SPAN << l;
            for (j = 0; j < WIDTH; j++) begin : g_cell
                if (j >= SPAN) begin : g_comb
                    assign lvl[l+1][j] = kpg_combine(lvl[l][j], lvl[l][j-SPAN]);
                end else begin : g_pass
                    assign lvl[l+1][j] = lvl[l][j];
                end
            end
        end

        for (j = 0; j < WIDTH; j++) begin : g_out
            assign kout[j] = lvl[NUM_LVLS][j];
        end
    endgenerate

endmodule

// File: rtl/prefix_sub_pipe.sv
// Two-stage pipelined KPG prefix subtractor: diff = a - b - bin (mod 2^WIDTH).
// Computed as a + ~b + ~bin. Stage 1 registers the prefix after SPLIT_LEVEL
// levels; stage 2 finishes the prefix, forms diff and flags, and registers them.
//  clk, rst           : clock, asynchronous active-high reset
//  in_valid/in_ready  : operand handshake (a, b, bin)
//  out_valid/out_ready: result handshake (diff, bout, zero, neg, ovf)
//  bout = 1 iff unsigned a < b + bin; ovf = signed overflow of a - b
module prefix_sub_pipe
    import vliw_alu_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int SPLIT_LEVEL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int NLVL    = $clog2(WIDTH);
    localparam int S2_LVLS = NLVL - SPLIT_LEVEL;
    localparam int S2_SPAN = 1 << SPLIT_LEVEL;

    // ---------------- stage 0: cell formation + first prefix levels
    logic [WIDTH-1:0] s0_nb;
    logic             s0_cin;
    kpg_t [WIDTH-1:0] s0_kin;
    kpg_t [WIDTH-1:0] s0_pre;

    assign s0_nb  = ~b;
    assign s0_cin = ~bin;

    // The carry-in is folded into bit 0 so that cell 0 is never P; after the
    // full prefix every cell is then K or G and directly gives its carry-out.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            s0_kin[i] = kpg_cell(a[i], s0_nb[i]);
        end
        s0_kin[0] = kpg_combine(s0_kin[0], s0_cin ? KPG_G : KPG_K);
    end

    kpg_prefix_levels #(
        .WIDTH      (WIDTH),
        .FIRST_SPAN (1),
        .NUM_LVLS   (SPLIT_LEVEL)
    ) u_lvl_s1 (
        .kin  (s0_kin),
        .kout (s0_pre)
    );

    // ---------------- stage 1 registers
    logic             s1_valid;
    kpg_t [WIDTH-1:0] s1_pre;
    logic [WIDTH-1:0] s1_p;
    logic             s1_cin;
    logic             s1_amsb;
    logic             s1_bmsb;

    // ---------------- stage 2: remaining levels, sum, flags
    kpg_t [WIDTH-1:0] s2_pre;
    logic [WIDTH:0]   s2_carry;
    logic [WIDTH-1:0] s2_diff;
    logic             s2_bout;
    logic             s2_zero;
    logic             s2_neg;
    logic             s2_ovf;

    kpg_prefix_levels #(
        .WIDTH      (WIDTH),
        .FIRST_SPAN (S2_SPAN),
        .NUM_LVLS   (S2_LVLS)
    ) u_lvl_s2 (
        .kin  (s1_pre),
        .kout (s2_pre)
    );

    always_comb begin
        s2_carry[0] = s1_cin;
        for (int i = 0; i < WIDTH; i++) begin
            s2_carry[i+1] = (s2_pre[i] == KPG_G);
        end
    end

    assign s2_diff = s1_p ^ s2_carry[WIDTH-1:0];
    assign s2_bout = ~s2_carry[WIDTH];
    assign s2_zero = (s2_diff == '0);
    assign s2_neg  = s2_diff[WIDTH-1];
    assign s2_ovf  = (s1_amsb != s1_bmsb) && (s2_diff[WIDTH-1] != s1_amsb);

    // ---------------- handshake
    logic s2_valid;
    logic s2_free;
    logic in_fire;
    logic s1_adv;

    assign s2_free  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign in_fire  = in_valid && in_ready;
    assign s1_adv   = s1_valid && s2_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_pre   <= '0;
            s1_p     <= '0;
            s1_cin   <= 1'b0;
            s1_amsb  <= 1'b0;
            s1_bmsb  <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_pre   <= s0_pre;
                s1_p     <= a ^ s0_nb;
                s1_cin   <= s0_cin;
                s1_amsb  <= a[WIDTH-1];
                s1_bmsb  <= b[WIDTH-1];
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Output registers only load when a beat moves into stage 2, so a stalled
    // or drained output keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
            zero     <= 1'b0;
            neg      <= 1'b0;
            ovf      <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                diff <= s2_diff;
                bout <= s2_bout;
                zero <= s2_zero;
                neg  <= s2_neg;
                ovf  <= s2_ovf;
            end
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_prefix_sub_pipe.sv
module tb_prefix_sub_pipe;

    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
        logic         neg;
        logic         ovf;
    } res_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         neg;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    prefix_sub_pipe #(.WIDTH(W), .SPLIT_LEVEL(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain (WIDTH+1)-bit arithmetic, flags straight from their definitions.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        logic [W:0] r;
        res_t m;
        r      = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        m.diff = r[W-1:0];
        m.bout = r[W];
        m.zero = (r[W-1:0] == '0);
        m.neg  = r[W-1];
        m.ovf  = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        return m;
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // One cycle: drive inputs after the falling edge, observe just before the rising edge.
    task automatic step(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic bi, input logic rdy,
                        output logic ir, output logic acc, output logic ov,
                        output logic oacc, output res_t got);
        @(negedge clk);
        in_valid  = v;
        a         = aa;
        b         = bb;
        bin       = bi;
        out_ready = rdy;
        #1;
        ir   = in_ready;
        acc  = in_valid && in_ready;
        ov   = out_valid;
        oacc = out_valid && out_ready;
        got  = '{diff, bout, zero, neg, ovf};
    endtask

    // Send one beat and collect its result with out_ready held high.
    task automatic run_one(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi,
                           output res_t got, output logic timeout);
        logic ir, acc, ov, oacc;
        res_t g;
        int   n;
        timeout = 1'b1;
        got     = '0;
        n       = 0;
        acc     = 1'b0;
        while (!acc && n < 20) begin
            step(1'b1, aa, bb, bi, 1'b1, ir, acc, ov, oacc, g);
            n++;
        end
        if (!acc) return;
        n    = 0;
        oacc = 1'b0;
        while (!oacc && n < 20) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, ir, acc, ov, oacc, g);
            n++;
        end
        if (oacc) begin
            got     = g;
            timeout = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic ir, acc, ov, oacc;
        res_t g;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== '0 || bout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b diff=%h bout=%b, required 0 1 0 0",
                     out_valid, in_ready, diff, bout);
        end
        @(negedge clk);
        rst = 1'b0;

        // two beats in flight, then reset mid-cycle
        step(1'b1, 64'd100, 64'd1, 1'b0, 1'b0, ir, acc, ov, oacc, g);
        step(1'b1, 64'd200, 64'd2, 1'b0, 1'b0, ir, acc, ov, oacc, g);
        @(posedge clk);
        #2;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_prefill: out_valid=%b in_ready=%b, required 1 0", out_valid, in_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || diff !== '0) begin
            errors++;
            $display("FAIL reset_async: out_valid=%b diff=%h, required 0 0", out_valid, diff);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        step(1'b0, '0, '0, 1'b0, 1'b1, ir, acc, ov, oacc, g);
        checks++;
        if (ir !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: in_ready=%b, required 1", ir);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, ir, acc, ov, oacc, g);
            checks++;
            if (ov !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_stale: cycle %0d out_valid=%b, required 0", i, ov);
            end
        end
    endtask

    task automatic test_basic();
        logic ir, acc, ov, oacc;
        res_t g, exp;
        exp = model(64'h10, 64'h3, 1'b0);
        step(1'b1, 64'h10, 64'h3, 1'b0, 1'b1, ir, acc, ov, oacc, g);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL basic_accept: accepted=%b, required 1", acc);
        end
        step(1'b0, '0, '0, 1'b0, 1'b1, ir, acc, ov, oacc, g);
        checks++;
        if (ov !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency1: out_valid=%b one cycle after accept, required 0", ov);
        end
        step(1'b0, '0, '0, 1'b0, 1'b1, ir, acc, ov, oacc, g);
        checks++;
        if (ov !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency2: out_valid=%b two cycles after accept, required 1", ov);
        end
        checks++;
        if (g !== exp || g.diff !== 64'hD || {g.bout, g.zero, g.neg, g.ovf} !== 4'b0000) begin
            errors++;
            $display("FAIL basic_result: got diff=%h b/z/n/o=%b%b%b%b, required diff=%h b/z/n/o=%b%b%b%b",
                     g.diff, g.bout, g.zero, g.neg, g.ovf,
                     exp.diff, exp.bout, exp.zero, exp.neg, exp.ovf);
        end
    endtask

    task automatic test_wrap();
        res_t g;
        logic to;
        run_one(64'd0, 64'd1, 1'b0, g, to);
        checks++;
        if (to || g.diff !== {W{1'b1}} || g.bout !== 1'b1 || g.neg !== 1'b1 || g.zero !== 1'b0) begin
            errors++;
            $display("FAIL wrap_0_minus_1: timeout=%b diff=%h bout=%b neg=%b zero=%b, required all-ones 1 1 0",
                     to, g.diff, g.bout, g.neg, g.zero);
        end
        run_one(64'd5, 64'd5, 1'b1, g, to);
        checks++;
        if (to || g !== model(64'd5, 64'd5, 1'b1) || g.diff !== {W{1'b1}} || g.bout !== 1'b1) begin
            errors++;
            $display("FAIL wrap_equal_bin: timeout=%b diff=%h bout=%b, required all-ones 1",
                     to, g.diff, g.bout);
        end
    endtask

    task automatic test_ovf();
        res_t g;
        logic to;
        run_one(64'h8000_0000_0000_0000, 64'd1, 1'b0, g, to);
        checks++;
        if (to || g.diff !== 64'h7FFF_FFFF_FFFF_FFFF || g.ovf !== 1'b1 || g.bout !== 1'b0 || g.neg !== 1'b0) begin
            errors++;
            $display("FAIL ovf_min_minus_1: timeout=%b diff=%h ovf=%b bout=%b neg=%b, required 7fff..ff 1 0 0",
                     to, g.diff, g.ovf, g.bout, g.neg);
        end
        run_one(64'h1234, 64'h1234, 1'b0, g, to);
        checks++;
        if (to || g.zero !== 1'b1 || g.bout !== 1'b0 || g.diff !== '0) begin
            errors++;
            $display("FAIL zero_equal: timeout=%b zero=%b bout=%b diff=%h, required 1 0 0",
                     to, g.zero, g.bout, g.diff);
        end
        run_one(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, g, to);
        checks++;
        if (to || g !== model(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0)) begin
            errors++;
            $display("FAIL ovf_max_minus_neg1: timeout=%b diff=%h ovf=%b bout=%b, required 8000..00 1 1",
                     to, g.diff, g.ovf, g.bout);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] va [6];
        logic [W-1:0] vb [6];
        logic         vbi [6];
        res_t         expq [$];
        logic ir, acc, ov, oacc;
        res_t g, held;
        int   sent, rcvd, n;
        for (int i = 0; i < 6; i++) begin
            va[i]  = rnd64();
            vb[i]  = rnd64();
            vbi[i] = 1'($urandom_range(0, 1));
        end
        sent = 0;
        rcvd = 0;
        held = '0;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, va[sent], vb[sent], vbi[sent], 1'b0, ir, acc, ov, oacc, g);
            if (acc) begin
                expq.push_back(model(va[sent], vb[sent], vbi[sent]));
                sent++;
            end
            if (c >= 2) begin
                checks++;
                if (ir !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_in_ready: stall cycle %0d in_ready=%b, required 0", c, ir);
                end
            end
            if (c == 2) held = g;
            if (c == 3) begin
                checks++;
                if (ov !== 1'b1 || g !== held) begin
                    errors++;
                    $display("FAIL bp_hold: out_valid=%b diff=%h, required 1 %h", ov, g.diff, held.diff);
                end
            end
        end
        checks++;
        if (sent != 2) begin
            errors++;
            $display("FAIL bp_accepts: accepted %0d beats under full stall, required 2", sent);
        end
        n = 0;
        while (rcvd < 6 && n < 40) begin
            if (sent < 6) step(1'b1, va[sent], vb[sent], vbi[sent], 1'b1, ir, acc, ov, oacc, g);
            else          step(1'b0, '0, '0, 1'b0, 1'b1, ir, acc, ov, oacc, g);
            if (acc) begin
                expq.push_back(model(va[sent], vb[sent], vbi[sent]));
                sent++;
            end
            if (oacc) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL bp_order: unexpected output diff=%h, required none", g.diff);
                end else if (g !== expq[0]) begin
                    errors++;
                    $display("FAIL bp_order: beat %0d diff=%h flags=%b, required %h flags=%b",
                             rcvd, g.diff, {g.bout, g.zero, g.neg, g.ovf},
                             expq[0].diff, {expq[0].bout, expq[0].zero, expq[0].neg, expq[0].ovf});
                end
                if (expq.size() != 0) void'(expq.pop_front());
                rcvd++;
            end
            n++;
        end
        checks++;
        if (rcvd != 6) begin
            errors++;
            $display("FAIL bp_count: received %0d results, required 6", rcvd);
        end
    endtask

    task automatic test_random();
        localparam int N = 10000;
        res_t         expq [$];
        logic [W-1:0] pa, pb;
        logic         pbi, have;
        logic         v, rdy, ir, acc, ov, oacc;
        logic         prev_stall;
        res_t         g, prev_g;
        int           sent, rcvd, cyc;
        sent       = 0;
        rcvd       = 0;
        cyc        = 0;
        have       = 1'b0;
        prev_stall = 1'b0;
        prev_g     = '0;
        pa = '0; pb = '0; pbi = 1'b0;
        while (rcvd < N && cyc < 60000) begin
            if (!have && sent < N) begin
                pa  = rnd64();
                case ($urandom_range(0, 7))
                    0:       pb = pa;
                    1:       pb = pa + 64'd1;
                    2:       pb = '0;
                    default: pb = rnd64();
                endcase
                pbi  = 1'($urandom_range(0, 1));
                have = 1'b1;
            end
            v   = have && ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(v, pa, pb, pbi, rdy, ir, acc, ov, oacc, g);
            if (prev_stall) begin
                checks++;
                if (ov !== 1'b1 || g !== prev_g) begin
                    errors++;
                    $display("FAIL rnd_hold: cycle %0d out_valid=%b diff=%h, required 1 %h",
                             cyc, ov, g.diff, prev_g.diff);
                end
            end
            if (acc) begin
                expq.push_back(model(pa, pb, pbi));
                sent++;
                have = 1'b0;
            end
            if (oacc) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_result: spurious output diff=%h at cycle %0d", g.diff, cyc);
                end else begin
                    if (g !== expq[0]) begin
                        errors++;
                        $display("FAIL rnd_result: beat %0d diff=%h flags=%b, required %h flags=%b",
                                 rcvd, g.diff, {g.bout, g.zero, g.neg, g.ovf},
                                 expq[0].diff, {expq[0].bout, expq[0].zero, expq[0].neg, expq[0].ovf});
                    end
                    void'(expq.pop_front());
                end
                rcvd++;
            end
            prev_stall = ov && !rdy;
            prev_g     = g;
            cyc++;
        end
        checks++;
        if (rcvd != N || expq.size() != 0) begin
            errors++;
            $display("FAIL rnd_count: received %0d of %0d, %0d still expected", rcvd, N, expq.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_ovf();
        test_backpressure();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
